ysyx_25030093_mem_arbiter: RTL and testbench
============================================

# ysyx_25030093_mem_arbiter

Two-master, one-slave memory arbiter sharing the single memory port between the IFU (instruction fetch, master 0) and the LSU (load/store, master 1). It accepts one request at a time, forwards it to the memory slave (SRAM model) and routes the response back to the requester. Grant is round-robin when both masters request in the same cycle. It sits between IFU/LSU and the memory slave in the core top.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (write mask is DATA_W/8 bits)

Ports (mN_ = master 0 IFU / master 1 LSU, identical sets):
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  reset
- mN_req_valid  in  1  master request valid
- mN_req_ready  out  1  request accepted by arbiter
- mN_addr  in  ADDR_W  request address
- mN_wen  in  1  1 = write, 0 = read
- mN_wdata  in  DATA_W  write data
- mN_wmask  in  DATA_W/8  byte write mask
- mN_resp_valid  out  1  response valid to master
- mN_resp_ready  in  1  master accepts response
- mN_rdata  out  DATA_W  read data (0 for writes)
- mN_resp_err  out  1  slave error flag
- s_req_valid  out  1  request valid to slave
- s_req_ready  in  1  slave accepts request
- s_addr, s_wen, s_wdata, s_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- s_resp_valid  in  1  slave response valid
- s_resp_ready  out  1  arbiter accepts response
- s_rdata  in  DATA_W  slave read data
- s_resp_err  in  1  slave error

## Operation
- FSM states: IDLE, SEND, RESP. Registers: state, grant (1 bit), last_grant (1 bit), latched addr/wen/wdata/wmask.
- IDLE: if any mN_req_valid, select winner: only one valid -> that one; both valid -> master != last_grant. mW_req_ready = 1 combinationally in that cycle, other master's req_ready = 0. On clock edge: latch winner's fields, grant <= W, last_grant <= W, state <= SEND.
- SEND: s_req_valid = 1 with latched fields; fields stable until s_req_valid && s_req_ready, then state <= RESP.
- RESP: s_resp_ready = m[grant]_resp_ready; m[grant]_resp_valid = s_resp_valid; m[grant]_rdata/resp_err = s_rdata/s_resp_err (passthrough). Non-granted master resp_valid = 0, rdata = 0, resp_err = 0. On s_resp_valid && s_resp_ready: state <= IDLE.
- Outside IDLE both mN_req_ready = 0; requests wait (masters hold valid and fields).
- s_resp_valid in IDLE/SEND is ignored (s_resp_ready = 0).
- Only one transaction outstanding; no reordering, no address decode.

## Timing
- Reset (rst high at clock edge): state = IDLE, grant = 0, last_grant = 1 (IFU wins first tie), latched fields = 0; hence all valid/ready outputs 0, s_addr/s_wdata/s_wmask/s_wen = 0, rdata/resp_err outputs 0.
- Reset mid-transaction (SEND or RESP): transaction abandoned, return to IDLE next edge; no response delivered to master. Slave shares rst.
- Latency: accept in cycle T (IDLE), s_req_valid from T+1; zero-wait slave (req_ready=1 at T+1, resp_valid at T+2) -> master response at T+2. Minimum 3 cycles per transaction; next grant earliest cycle after response handshake.
- Request fields sampled only at the IDLE accept edge; later master changes do not affect s_*.
- Backpressure: slave holding s_req_ready = 0 keeps SEND indefinitely; master holding resp_ready = 0 keeps RESP and s_resp_ready = 0.
- Simultaneous request from both masters in IDLE: exactly one req_ready high, alternating across consecutive ties.

## Test plan
- Reset then single IFU read addr 0x8000_0000, slave returns 0x0000_0413 after 1 cycle -> m0_req_ready at T, s_req_valid T+1 with s_addr 0x8000_0000, s_wen 0, m0_resp_valid with rdata 0x0000_0413; m1 outputs stay 0.
- LSU write addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF -> s_wen 1 and fields exact; m1_resp_valid one cycle on slave response, m0 untouched.
- Both request every cycle, 4 transactions -> grant order IFU, LSU, IFU, LSU; losing master's req_ready low while other's transaction in flight.
- Slave stalls s_req_ready low 5 cycles, then master stalls resp_ready 3 cycles -> s_* fields stable throughout, s_resp_ready mirrors m_resp_ready, single handshake each side.
- Assert rst during RESP with s_resp_valid high -> next cycle IDLE, no mN_resp_valid, all outputs 0; following IFU+LSU tie granted to IFU.
- Slave returns s_resp_err = 1 on LSU read -> m1_resp_err = 1 in the response cycle, arbiter returns to IDLE normally.

Source files
------------

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Two-master (IFU = m0, LSU = m1) to one-slave memory arbiter with round-robin
// tie-break and a single outstanding transaction.
module ysyx_25030093_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_resp_valid,
  input  logic                m0_resp_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_resp_err,

  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_resp_valid,
  input  logic                m1_resp_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_resp_err,

  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_resp_valid,
  output logic                s_resp_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_resp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state;
  logic                grant;
  logic                last_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  logic any_req;
  logic winner;
  logic accept;
  logic in_resp;
  logic sel_resp_ready;

  // On a tie the master that did not win last time gets the port.
  assign any_req = m0_req_valid | m1_req_valid;
  assign winner  = (m0_req_valid & m1_req_valid) ? ~last_grant : m1_req_valid;
  assign accept  = (state == IDLE) & any_req;

  assign m0_req_ready = accept & ~winner;
  assign m1_req_ready = accept & winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            addr_q     <= winner ? m1_addr  : m0_addr;
            wen_q      <= winner ? m1_wen   : m0_wen;
            wdata_q    <= winner ? m1_wdata : m0_wdata;
            wmask_q    <= winner ? m1_wmask : m0_wmask;
            state      <= SEND;
          end
        end
        SEND: begin
          if (s_req_ready) state <= RESP;
        end
        RESP: begin
          if (s_resp_valid && s_resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_req_valid = (state == SEND);
  assign s_addr      = addr_q;
  assign s_wen       = wen_q;
  assign s_wdata     = wdata_q;
  assign s_wmask     = wmask_q;

  // Response path is a passthrough steered to the granted master only.
  assign in_resp        = (state == RESP);
  assign sel_resp_ready = grant ? m1_resp_ready : m0_resp_ready;
  assign s_resp_ready   = in_resp & sel_resp_ready;

  assign m0_resp_valid = in_resp & ~grant & s_resp_valid;
  assign m0_rdata      = (in_resp & ~grant) ? s_rdata : '0;
  assign m0_resp_err   = in_resp & ~grant & s_resp_err;

  assign m1_resp_valid = in_resp & grant & s_resp_valid;
  assign m1_rdata      = (in_resp & grant) ? s_rdata : '0;
  assign m1_resp_err   = in_resp & grant & s_resp_err;

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: master drivers and a slave
// model run independently while a monitor checks grants, slave requests and responses.
module tb_ysyx_25030093_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    int          master;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready, m0_resp_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready, m1_resp_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready, s_resp_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;

  req_t  m0_pend[$];
  req_t  m1_pend[$];
  req_t  sreq_q[$];
  int    grant_q[$];
  resp_t resp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int stall_cnt = 0;

  ysyx_25030093_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_rdata(s_rdata), .s_resp_err(s_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic failNow(input string name, input string why);
    total_cnt++;
    $display("[TB] FAIL %s: %s", name, why);
  endtask

  // Queue a request on a master and record what the arbiter must do with it.
  task automatic applyStimulus(input int master, input logic [31:0] addr, input logic wen,
                               input logic [31:0] wdata, input logic [3:0] wmask,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input bit exp_resp);
    req_t  r;
    resp_t p;
    r.addr = addr; r.wen = wen; r.wdata = wdata; r.wmask = wmask;
    if (master == 0) m0_pend.push_back(r);
    else             m1_pend.push_back(r);
    grant_q.push_back(master);
    sreq_q.push_back(r);
    if (exp_resp) begin
      p.master = master; p.rdata = exp_rdata; p.err = exp_err;
      resp_q.push_back(p);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(m0_pend.size() == 0 && m1_pend.size() == 0 && grant_q.size() == 0 &&
             sreq_q.size() == 0 && resp_q.size() == 0 && !s_resp_valid) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= budget) failNow(name, $sformatf("still pending after %0d cycles, required drained", n));
  endtask

  task automatic wait_for_resp(input string name, input int budget);
    int n = 0;
    while (!s_resp_valid && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (!s_resp_valid) failNow(name, "slave response never appeared, required within budget");
  endtask

  function automatic logic [31:0] slave_rdata(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
  endfunction

  initial begin : m0_driver
    logic acc;
    req_t drop;
    forever begin
      @(negedge clk);
      acc = m0_req_valid && m0_req_ready && !rst;
      @(posedge clk); #1;
      if (acc && m0_pend.size() > 0) drop = m0_pend.pop_front();
      if (m0_pend.size() > 0) begin
        m0_req_valid = 1'b1; m0_addr = m0_pend[0].addr; m0_wen = m0_pend[0].wen;
        m0_wdata = m0_pend[0].wdata; m0_wmask = m0_pend[0].wmask;
      end else begin
        m0_req_valid = 1'b0; m0_addr = '0; m0_wen = 1'b0; m0_wdata = '0; m0_wmask = '0;
      end
    end
  end

  initial begin : m1_driver
    logic acc;
    req_t drop;
    forever begin
      @(negedge clk);
      acc = m1_req_valid && m1_req_ready && !rst;
      @(posedge clk); #1;
      if (acc && m1_pend.size() > 0) drop = m1_pend.pop_front();
      if (m1_pend.size() > 0) begin
        m1_req_valid = 1'b1; m1_addr = m1_pend[0].addr; m1_wen = m1_pend[0].wen;
        m1_wdata = m1_pend[0].wdata; m1_wmask = m1_pend[0].wmask;
      end else begin
        m1_req_valid = 1'b0; m1_addr = '0; m1_wen = 1'b0; m1_wdata = '0; m1_wmask = '0;
      end
    end
  end

  // Slave answers one cycle after accepting; addresses with nibble 0xE at [15:12] report an error.
  initial begin : slave_model
    logic        req_hs, resp_hs, rst_s, w;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      req_hs  = s_req_valid && s_req_ready;
      resp_hs = s_resp_valid && s_resp_ready;
      rst_s   = rst;
      a       = s_addr;
      w       = s_wen;
      @(posedge clk); #1;
      if (rst_s || resp_hs) begin
        s_resp_valid = 1'b0; s_rdata = '0; s_resp_err = 1'b0;
      end
      if (!rst_s && req_hs) begin
        s_resp_valid = 1'b1;
        s_rdata      = w ? 32'h0 : slave_rdata(a);
        s_resp_err   = (a[15:12] == 4'hE);
      end
      if (stall_cnt > 0) begin
        s_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        s_req_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    req_t  sr;
    resp_t rr;
    int    g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m0_req_valid || m1_req_valid)
          checkOutput("req_ready_exclusive", m0_req_ready & m1_req_ready, 0);
        if ((m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready)) begin
          if (grant_q.size() == 0) failNow("grant_unexpected", "accept seen, required none");
          else begin
            g = grant_q.pop_front();
            checkOutput("grant_order", m1_req_ready, g[0]);
          end
        end
        if (s_req_valid) begin
          checkOutput("busy_req_ready", {m0_req_ready, m1_req_ready}, 0);
          if (sreq_q.size() == 0) failNow("s_req_unexpected", "s_req_valid seen, required none");
          else begin
            sr = sreq_q[0];
            checkOutput("s_addr", s_addr, sr.addr);
            checkOutput("s_wen", s_wen, sr.wen);
            checkOutput("s_wdata", s_wdata, sr.wdata);
            checkOutput("s_wmask", s_wmask, sr.wmask);
            if (s_req_ready) sr = sreq_q.pop_front();
          end
        end
        if (m0_resp_valid || m1_resp_valid) begin
          checkOutput("resp_valid_exclusive", m0_resp_valid & m1_resp_valid, 0);
          checkOutput("s_resp_ready_mirror", s_resp_ready,
                      m1_resp_valid ? m1_resp_ready : m0_resp_ready);
          checkOutput("idle_master_zero",
                      m1_resp_valid ? {m0_rdata, 31'h0, m0_resp_err} : {m1_rdata, 31'h0, m1_resp_err}, 0);
          if ((m0_resp_valid && m0_resp_ready) || (m1_resp_valid && m1_resp_ready)) begin
            if (resp_q.size() == 0) failNow("resp_unexpected", "response handshake seen, required none");
            else begin
              rr = resp_q.pop_front();
              checkOutput("resp_master", m1_resp_valid, rr.master[0]);
              checkOutput("resp_rdata", m1_resp_valid ? m1_rdata : m0_rdata, rr.rdata);
              checkOutput("resp_err", m1_resp_valid ? m1_resp_err : m0_resp_err, rr.err);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    m0_req_valid = 0; m0_addr = 0; m0_wen = 0; m0_wdata = 0; m0_wmask = 0; m0_resp_ready = 1;
    m1_req_valid = 0; m1_addr = 0; m1_wen = 0; m1_wdata = 0; m1_wmask = 0; m1_resp_ready = 1;
    s_req_ready = 1; s_resp_valid = 0; s_rdata = 0; s_resp_err = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", {m0_req_ready, m1_req_ready}, 0);
    checkOutput("rst_s_req_valid", s_req_valid, 0);
    checkOutput("rst_s_fields", {s_addr, s_wdata, s_wmask, s_wen}, 0);
    checkOutput("rst_resp", {m0_resp_valid, m1_resp_valid, s_resp_ready, m0_resp_err, m1_resp_err}, 0);
    checkOutput("rst_rdata", {m0_rdata, m1_rdata}, 0);

    $display("[TB] single IFU read with latency");
    applyStimulus(0, 32'h8000_0000, 0, 32'h0, 4'h0, 32'h0000_0413, 0, 1);
    @(posedge clk); #2;
    checkOutput("t1_m0_req_ready", m0_req_ready, 1);
    checkOutput("t1_m1_req_ready", m1_req_ready, 0);
    @(posedge clk); #2;
    checkOutput("t1_s_req_valid", s_req_valid, 1);
    checkOutput("t1_s_addr", s_addr, 32'h8000_0000);
    @(posedge clk); #2;
    checkOutput("t1_m0_resp_valid", m0_resp_valid, 1);
    checkOutput("t1_m0_rdata", m0_rdata, 32'h0000_0413);
    checkOutput("t1_m1_quiet", {m1_resp_valid, m1_rdata, m1_resp_err}, 0);
    @(posedge clk); #2;
    checkOutput("t1_m0_resp_done", m0_resp_valid, 0);
    wait_done("t1_drain", 50);

    $display("[TB] LSU write");
    applyStimulus(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1);
    wait_done("t2_drain", 50);

    $display("[TB] both masters contending");
    applyStimulus(0, 32'h8000_0004, 0, 32'h0,         4'h0, 32'h9234_567C, 0, 1);
    applyStimulus(1, 32'h8000_1000, 1, 32'h1111_2222, 4'h3, 32'h0,         0, 1);
    applyStimulus(0, 32'h8000_0008, 0, 32'h0,         4'h0, 32'h9234_5670, 0, 1);
    applyStimulus(1, 32'h8000_2000, 0, 32'h0,         4'h0, 32'h9234_7678, 0, 1);
    applyStimulus(0, 32'h8000_000C, 0, 32'h0,         4'h0, 32'h9234_5674, 0, 1);
    wait_done("t3_drain", 100);

    $display("[TB] slave error on LSU read");
    applyStimulus(1, 32'h8000_E000, 0, 32'h0, 4'h0, 32'h9234_B678, 1, 1);
    wait_done("t4_drain", 50);

    $display("[TB] slave and master backpressure");
    stall_cnt = 5;
    m0_resp_ready = 1'b0;
    applyStimulus(0, 32'h8000_0010, 0, 32'h0, 4'h0, 32'h9234_5668, 0, 1);
    wait_for_resp("t5_resp_wait", 50);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      checkOutput("t5_s_resp_ready_held", s_resp_ready, 0);
      checkOutput("t5_m0_resp_valid_held", m0_resp_valid, 1);
    end
    m0_resp_ready = 1'b1;
    wait_done("t5_drain", 50);

    $display("[TB] reset during response");
    m0_resp_ready = 1'b0;
    applyStimulus(0, 32'h8000_0020, 0, 32'h0, 4'h0, 32'h0, 0, 0);
    wait_for_resp("t6_resp_wait", 50);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    m0_resp_ready = 1'b1;
    checkOutput("t6_resp_valid", {m0_resp_valid, m1_resp_valid, s_resp_ready}, 0);
    checkOutput("t6_s_req", {s_req_valid, s_addr, s_wen}, 0);
    checkOutput("t6_req_ready", {m0_req_ready, m1_req_ready}, 0);
    applyStimulus(0, 32'h8000_0030, 0, 32'h0,         4'h0, 32'h9234_5648, 0, 1);
    applyStimulus(1, 32'h8000_3000, 1, 32'hCAFE_F00D, 4'hC, 32'h0,         0, 1);
    wait_done("t6_drain", 50);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
